// File: rtl/mod_74xx_pkg.sv
// rtl/mod_74xx_pkg.sv - shared nibble constants and terminal-count helper for 74xx counter models
package mod_74xx_pkg;

    localparam int NIBBLE = 4;
    localparam logic [NIBBLE-1:0] NIBBLE_MAX = 4'hF;

    function automatic logic is_terminal(input logic [NIBBLE-1:0] q);
        return (q == NIBBLE_MAX);
    endfunction

endpackage

// File: rtl/mod_74x163_stage.sv
// rtl/mod_74x163_stage.sv - one 74x163 chip: 4-bit sync counter, load, optional CLR_n (MOD_74X163_CLR_EN)
module mod_74x163_stage
    import mod_74xx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
`ifdef MOD_74X163_CLR_EN
    input  logic              CLR_n,
`endif
    input  logic              ENP,
    input  logic              ENT,
    input  logic              LOAD_n,
    input  logic [0:NIBBLE-1] D,
    output logic [0:NIBBLE-1] Q,
    output logic              RCO
);

    logic [NIBBLE-1:0] count;
    logic [NIBBLE-1:0] d_val;
    logic              clr_n_int;

`ifdef MOD_74X163_CLR_EN
    assign clr_n_int = CLR_n;
`else
    assign clr_n_int = 1'b1;
`endif

    // Pins are numbered QA..QD as index 0..3 with QA the LSB of the count.
    always_comb begin
        d_val = '0;
        Q     = '0;
        for (int i = 0; i < NIBBLE; i++) begin
            d_val[i] = D[i];
            Q[i]     = count[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (!clr_n_int) begin
            count <= '0;
        end else if (!LOAD_n) begin
            count <= d_val;
        end else if (ENP && ENT) begin
            count <= count + 1'b1;
        end
    end

    assign RCO = ENT && is_terminal(count);

endmodule

// File: rtl/mod_74x163_chain.sv
// rtl/mod_74x163_chain.sv - STAGES x 74x163 chained RCO->ENT; MOD_74X163_CLR_EN adds CLR_n
module mod_74x163_chain
    import mod_74xx_pkg::*;
#(
    parameter int STAGES = 1,
    localparam int W = NIBBLE * STAGES
) (
    input  logic         CLK,
    input  logic         RST,
`ifdef MOD_74X163_CLR_EN
    input  logic         CLR_n,
`endif
    input  logic         ENP,
    input  logic         ENT,
    input  logic         LOAD_n,
    input  logic [0:W-1] D,
    output logic [0:W-1] Q,
    output logic         RCO
);

    // Each stage gets its own ent/rco nets so the carry ripple is not a self-loop on one vector.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic ent_in;
        logic rco_out;

        if (g == 0) begin : g_first
            assign ent_in = ENT;
        end else begin : g_next
            assign ent_in = g_stage[g-1].rco_out;
        end

        mod_74x163_stage u_stage (
            .CLK    (CLK),
            .RST    (RST),
`ifdef MOD_74X163_CLR_EN
            .CLR_n  (CLR_n),
`endif
            .ENP    (ENP),
            .ENT    (ent_in),
            .LOAD_n (LOAD_n),
            .D      (D[NIBBLE*g +: NIBBLE]),
            .Q      (Q[NIBBLE*g +: NIBBLE]),
            .RCO    (rco_out)
        );
    end

    assign RCO = g_stage[STAGES-1].rco_out;

endmodule

// File: tb/tb_mod_74x163_chain.sv
// tb/tb_mod_74x163_chain.sv - self-checking bench for mod_74x163_chain at STAGES=2 (MOD_74X163_CLR_EN optional)
module tb_mod_74x163_chain;

    localparam int STAGES = 2;
    localparam int W = 4 * STAGES;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         CLR_n = 1'b1;
    logic         ENP = 1'b0;
    logic         ENT = 1'b0;
    logic         LOAD_n = 1'b1;
    logic [0:W-1] D;
    logic [0:W-1] Q;
    logic         RCO;

    int checks = 0;
    int failures = 0;
    int model_q = 0;

    always #5 CLK = ~CLK;

    mod_74x163_chain #(.STAGES(STAGES)) dut (
        .CLK    (CLK),
        .RST    (RST),
`ifdef MOD_74X163_CLR_EN
        .CLR_n  (CLR_n),
`endif
        .ENP    (ENP),
        .ENT    (ENT),
        .LOAD_n (LOAD_n),
        .D      (D),
        .Q      (Q),
        .RCO    (RCO)
    );

    function automatic logic [0:W-1] to_bus(input int v);
        logic [0:W-1] b;
        for (int i = 0; i < W; i++) b[i] = v[i];
        return b;
    endfunction

    function automatic int from_bus(input logic [0:W-1] b);
        int v;
        v = 0;
        for (int i = 0; i < W; i++) if (b[i] === 1'b1) v += (1 << i);
        return v;
    endfunction

    function automatic int load_val();
        int v;
        v = 0;
        for (int i = 0; i < W; i++) if (D[i]) v += (1 << i);
        return v;
    endfunction

    task automatic check(input string tag);
        int exp_q;
        logic exp_rco;
        exp_q   = model_q;
        exp_rco = ENT && (model_q == (1 << W) - 1);
        checks++;
        assert (!$isunknown(Q) && from_bus(Q) === exp_q)
        else begin
            failures++;
            $error("FAIL %s Q observed=%02h expected=%02h", tag, from_bus(Q), exp_q);
        end
        checks++;
        assert (RCO === exp_rco)
        else begin
            failures++;
            $error("FAIL %s RCO observed=%b expected=%b", tag, RCO, exp_rco);
        end
    endtask

    // Reference: counter value as an integer mod 2^W, priority order applied directly.
    task automatic tick(input string tag);
        @(posedge CLK);
        if (RST) model_q = 0;
        else if (!CLR_n) model_q = 0;
        else if (!LOAD_n) model_q = load_val();
        else if (ENP && ENT) model_q = (model_q + 1) % (1 << W);
        #1;
        check(tag);
    endtask

    task automatic load(input int v, input string tag);
        LOAD_n = 1'b0;
        D = to_bus(v);
        tick(tag);
        LOAD_n = 1'b1;
    endtask

    initial begin
        D = to_bus(0);
        #1;

        RST = 1'b1; LOAD_n = 1'b0; D = to_bus(8'hA5); ENP = 1'b1; ENT = 1'b1;
        tick("reset_beats_load");
        RST = 1'b0; LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b0;

        load(8'h0E, "load_0e");
        ENP = 1'b1; ENT = 1'b1;
        tick("count_0f");
        tick("carry_10");

        load(8'hFE, "load_fe");
        tick("count_ff");
        ENP = 1'b0; #1; check("rco_enp_low");
        tick("hold_ff");
        ENT = 1'b0; #1; check("rco_ent_low");
        ENP = 1'b1; ENT = 1'b1;
        tick("wrap_00");

        load(8'h3C, "load_3c");
        ENP = 1'b1; ENT = 1'b0;
        repeat (5) tick("hold_ent0");
        ENP = 1'b0; ENT = 1'b1;
        repeat (5) tick("hold_enp0");

        load(8'h7E, "load_7e");
        ENP = 1'b1; ENT = 1'b1;
        tick("count_7f");
        RST = 1'b1;
        tick("mid_reset");
        RST = 1'b0;
        tick("after_reset_01");

`ifdef MOD_74X163_CLR_EN
        CLR_n = 1'b0; LOAD_n = 1'b0; D = to_bus(8'h55);
        tick("clr_beats_load");
        CLR_n = 1'b1; LOAD_n = 1'b1;
        tick("after_clr_01");
`endif

        for (int n = 0; n < 400; n++) begin
            RST    = ($urandom_range(0, 24) == 0);
            LOAD_n = ($urandom_range(0, 5) != 0);
`ifdef MOD_74X163_CLR_EN
            CLR_n  = ($urandom_range(0, 15) != 0);
`endif
            ENP    = ($urandom_range(0, 3) != 0);
            ENT    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) D = to_bus(256 - int'($urandom_range(1, 4)));
            else D = to_bus(int'($urandom_range(0, 255)));
            tick("random");
            #1; check("random_comb");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
